collatz_range_mc: RTL and testbench
===================================

Name: collatz_range_mc

Overview:
Parametrised, multi-channel successor to the single-iterator Collatz range scanner. A `go` pulse latches a start value. The block then fans the RAM_WORDS consecutive numbers start..start+RAM_WORDS-1 out over N_CH parallel iterator channels. Each result is written to an on-chip RAM at offset (n - start), with saturation and overflow flags. A host reads results through an independent read port with 1-cycle latency; this block replaces the single-channel scanner in the lab top level.

Parameters:
N_BITS, 32, width of start value and iterator datapath
CNT_BITS, 16, width of stored term count
N_CH, 4, number of parallel iterator channels (1..16)
RAM_WORDS, 16, results per run (power of two)
RAM_ADDR_BITS, 4, log2(RAM_WORDS)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
go  in  1  one-cycle start pulse; latches start
start  in  N_BITS  first number of the range
rd_addr  in  RAM_ADDR_BITS  result read address
count  out  CNT_BITS  term count at rd_addr, registered
flag  out  1  sat/ovf flag of word at rd_addr, registered
busy  out  1  run in progress
done  out  1  all RAM_WORDS results written; held until next go

Behaviour:
- Reset (async assert, sync deassert by clk): busy=0, done=0, count=0, flag=0, all channels idle, dispatch pointer=0, write counter=0. RAM contents are not reset and are not checked after reset.
- Term count k(n): number of sequence terms including n and the final 1. k(1)=1, k(2)=2, k(3)=8.
- Go handling:
  - `go` in cycle 0 latches start, sets busy=1, clears done at cycle 1.
  - `go` while busy aborts the run: channels cleared, run restarts from the new start. Results already written are overwritten as the new run proceeds.
- Dispatcher:
  - From cycle 1, at most one number per cycle goes to the lowest-index idle channel.
  - Numbers are issued in order start, start+1, ... until RAM_WORDS have been issued.
  - The channel stores tag = offset (RAM_ADDR_BITS).
- Channel on load:
  - v=n, cnt=1.
  - Then, one step per cycle: if v==1, finish. Else v = v even ? v>>1 : 3v+1, computed in N_BITS+2 bits, and cnt++.
  - Total occupancy for a number with k terms: k cycles plus the write wait.
- Special cases (flag=1 in each):
  - n==0: finishes the cycle after load with cnt = all ones.
  - 3v+1 > 2^N_BITS-1 (overflow): finishes with the current cnt; v is not updated.
  - cnt reaching 2^CNT_BITS-1 before v==1 (saturation): finishes with cnt = all ones.
- Write arbitration:
  - One RAM write per cycle. Word = {flag, cnt} written at the tag address.
  - If several channels finish together, the lowest index writes first. Others hold their result (and stay busy) until granted.
  - A channel becomes idle the cycle after its write and may be reloaded in that same cycle.
- Completion: write counter increments per write. On the RAM_WORDS-th write, busy=0 and done=1 from the next cycle, held until `go` or reset.
- Read port:
  - count/flag valid 1 cycle after rd_addr, at all times, including during a run.
  - Same-cycle write and read of the same address returns the old data (read-before-write).
- start+i wraps modulo 2^N_BITS; a wrapped 0 is handled as n==0.
- Reset mid-run: immediate abort to the reset state.

Decomposition:
- Package collatz_pkg holds:
  - typedef `ch_state_e` {IDLE, RUN, WAIT_WR}
  - a function for the next-term and overflow check
  - localparam CNT_MAX
- Sub-module collatz_ch: one iterator channel with load/tag inputs and finish/grant handshake, instantiated N_CH times by generate.
- Arbiter, dispatcher and RAM stay in the top module.

Test Plan:
- Default params, go with start=1 -> after done, rd_addr 0..15 read counts 1,2,8,3,6,9,17,4,20,7,15,10,10,18,18,5, all flag=0; busy low and done high simultaneously.
- start=0 -> word0 = 0xFFFF with flag=1; word1 = 1, word2 = 2, word3 = 8, flag=0.
- N_BITS=8, start=27 -> word0 count=12, flag=1 (overflow at 107 -> 322); word1 (n=28) = 19, flag=0.
- CNT_BITS=4, start=27 -> word0 count=15, flag=1 (saturated); word1 (n=28) = 15, flag=1; word2 (n=29) = 15, flag=1; word5 (n=32) = 6, flag=0.
- N_CH=1 vs N_CH=8 with start=1 -> identical RAM contents; N_CH=8 run strictly shorter; cover point: two channels finishing in the same cycle, lower index written first.
- Abort and reset:
  - `go` start=1, then `go` start=100 after 10 cycles -> final words are k(100..115), e.g. word0=26.
  - reset_n low mid-run -> busy=0, done=0 immediately.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types and the Collatz step function for the multi-channel range scanner.
// The step is computed at a fixed wide width so any N_BITS up to 64 fits without overflow.
package collatz_pkg;

    localparam int unsigned MAX_W        = 66;
    localparam int unsigned CNT_BITS_MAX = 32;
    localparam logic [CNT_BITS_MAX-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_WR} ch_state_e;

    typedef struct packed {
        logic [MAX_W-1:0] nxt;
        logic             ovf;
    } step_t;

    // ovf is set when the next term no longer fits in n_bits.
    function automatic step_t next_term(input logic [MAX_W-1:0] v, input int unsigned n_bits);
        step_t s;
        s.nxt = v[0] ? (v + (v << 1) + MAX_W'(1)) : (v >> 1);
        s.ovf = (s.nxt >> n_bits) != '0;
        return s;
    endfunction

endpackage

// File: rtl/collatz_range_mc_if.sv
// Host-side bus of the Collatz range scanner: start handshake, status and read port.
interface collatz_range_mc_if #(
    parameter int unsigned N_BITS        = 32,
    parameter int unsigned CNT_BITS      = 16,
    parameter int unsigned RAM_ADDR_BITS = 4
);
    logic                     go;
    logic [N_BITS-1:0]        start;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic [CNT_BITS-1:0]      count;
    logic                     flag;
    logic                     busy;
    logic                     done;

    modport master (output go, start, rd_addr, input count, flag, busy, done);
    modport slave  (input go, start, rd_addr, output count, flag, busy, done);
endinterface

// File: rtl/collatz_ch.sv
// One Collatz iterator channel: load a number, count its terms, hold the result until granted.
module collatz_ch
    import collatz_pkg::*;
#(
    parameter int unsigned N_BITS   = 32,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned TAG_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [N_BITS-1:0]   n_i,
    input  logic [TAG_BITS-1:0] tag_i,
    input  logic                grant_i,
    output logic                idle_o,
    output logic                finish_o,
    output logic [CNT_BITS-1:0] cnt_o,
    output logic                flag_o,
    output logic [TAG_BITS-1:0] tag_o
);

    localparam logic [CNT_BITS-1:0] CntSat = CNT_MAX[CNT_BITS-1:0];

    ch_state_e           state_q;
    logic [N_BITS-1:0]   v_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                flag_q;
    logic [TAG_BITS-1:0] tag_q;
    step_t               step;
    logic                unused_step_hi;

    assign step           = next_term(MAX_W'(v_q), N_BITS);
    assign unused_step_hi = ^step.nxt[MAX_W-1:N_BITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            tag_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_i) begin
                        state_q <= RUN;
                        v_q     <= n_i;
                        cnt_q   <= CNT_BITS'(1);
                        flag_q  <= 1'b0;
                        tag_q   <= tag_i;
                    end
                end
                RUN: begin
                    if (v_q == N_BITS'(1)) begin
                        state_q <= WAIT_WR;
                    end else if (v_q == '0) begin
                        cnt_q   <= CntSat;
                        flag_q  <= 1'b1;
                        state_q <= WAIT_WR;
                    end else if (step.ovf) begin
                        // keep the count of terms that still fitted
                        flag_q  <= 1'b1;
                        state_q <= WAIT_WR;
                    end else if (cnt_q == CntSat) begin
                        flag_q  <= 1'b1;
                        state_q <= WAIT_WR;
                    end else begin
                        v_q   <= step.nxt[N_BITS-1:0];
                        cnt_q <= cnt_q + CNT_BITS'(1);
                    end
                end
                WAIT_WR: begin
                    if (grant_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o   = (state_q == IDLE);
    assign finish_o = (state_q == WAIT_WR);
    assign cnt_o    = cnt_q;
    assign flag_o   = flag_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/collatz_range_mc.sv
// Multi-channel Collatz range scanner: dispatches start..start+RAM_WORDS-1 over N_CH
// iterator channels and stores {flag, count} per offset in a result RAM.
module collatz_range_mc
    import collatz_pkg::*;
#(
    parameter int unsigned N_BITS        = 32,
    parameter int unsigned CNT_BITS      = 16,
    parameter int unsigned N_CH          = 4,
    parameter int unsigned RAM_WORDS     = 16,
    parameter int unsigned RAM_ADDR_BITS = 4
) (
    input logic               clk,
    input logic               reset_n,
    collatz_range_mc_if.slave bus
);

    localparam int unsigned CW = RAM_ADDR_BITS + 1;

    logic                     busy_q;
    logic                     done_q;
    logic [N_BITS-1:0]        start_q;
    logic [CW-1:0]            issue_q;
    logic [CW-1:0]            wr_cnt_q;
    logic [CNT_BITS:0]        rd_q;
    logic [CNT_BITS:0]        mem_q [RAM_WORDS];

    logic [N_CH-1:0]          idle;
    logic [N_CH-1:0]          finish;
    logic [N_CH-1:0]          load;
    logic [N_CH-1:0]          grant;
    logic [CNT_BITS-1:0]      ch_cnt  [N_CH];
    logic                     ch_flag [N_CH];
    logic [RAM_ADDR_BITS-1:0] ch_tag  [N_CH];
    logic [N_BITS-1:0]        next_n;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [CNT_BITS:0]        wr_data;
    logic                     active;

    // No dispatch or write in the go cycle: the channels are being cleared.
    assign active = busy_q && !bus.go;
    assign next_n = start_q + N_BITS'(issue_q);

    // Lowest set bit wins, for both dispatch and write arbitration.
    always_comb begin
        load  = '0;
        grant = '0;
        if (active && (issue_q < CW'(RAM_WORDS))) begin
            load = idle & (~idle + N_CH'(1));
        end
        if (active) begin
            grant = finish & (~finish + N_CH'(1));
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                wr_addr = ch_tag[i];
                wr_data = {ch_flag[i], ch_cnt[i]};
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        collatz_ch #(
            .N_BITS  (N_BITS),
            .CNT_BITS(CNT_BITS),
            .TAG_BITS(RAM_ADDR_BITS)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .clear_i (bus.go),
            .load_i  (load[g]),
            .n_i     (next_n),
            .tag_i   (issue_q[RAM_ADDR_BITS-1:0]),
            .grant_i (grant[g]),
            .idle_o  (idle[g]),
            .finish_o(finish[g]),
            .cnt_o   (ch_cnt[g]),
            .flag_o  (ch_flag[g]),
            .tag_o   (ch_tag[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= '0;
            issue_q  <= '0;
            wr_cnt_q <= '0;
        end else if (bus.go) begin
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            start_q  <= bus.start;
            issue_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (|load) issue_q <= issue_q + CW'(1);
            if (|grant) begin
                wr_cnt_q <= wr_cnt_q + CW'(1);
                if (wr_cnt_q == CW'(RAM_WORDS - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|grant) mem_q[wr_addr] <= wr_data;
    end

    // Non-blocking read of mem_q gives read-before-write on an address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_q <= '0;
        else          rd_q <= mem_q[bus.rd_addr];
    end

    assign bus.count = rd_q[CNT_BITS-1:0];
    assign bus.flag  = rd_q[CNT_BITS];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_collatz_range_mc.sv
// Self-checking bench: five scanner configurations driven in lockstep, results checked
// against a constant table and a term-count reference through a read scoreboard.
module tb_collatz_range_mc;

    localparam int NDUT = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [31:0] start;
    logic [3:0]  rd_addr;

    always #5 clk = ~clk;

    collatz_range_mc_if #(.N_BITS(32), .CNT_BITS(16), .RAM_ADDR_BITS(4)) if0 ();
    collatz_range_mc_if #(.N_BITS(32), .CNT_BITS(16), .RAM_ADDR_BITS(4)) if1 ();
    collatz_range_mc_if #(.N_BITS(32), .CNT_BITS(16), .RAM_ADDR_BITS(4)) if2 ();
    collatz_range_mc_if #(.N_BITS(8),  .CNT_BITS(16), .RAM_ADDR_BITS(4)) if3 ();
    collatz_range_mc_if #(.N_BITS(32), .CNT_BITS(4),  .RAM_ADDR_BITS(4)) if4 ();

    collatz_range_mc #(.N_BITS(32), .CNT_BITS(16), .N_CH(4), .RAM_WORDS(16), .RAM_ADDR_BITS(4))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    collatz_range_mc #(.N_BITS(32), .CNT_BITS(16), .N_CH(1), .RAM_WORDS(16), .RAM_ADDR_BITS(4))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    collatz_range_mc #(.N_BITS(32), .CNT_BITS(16), .N_CH(8), .RAM_WORDS(16), .RAM_ADDR_BITS(4))
        u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    collatz_range_mc #(.N_BITS(8), .CNT_BITS(16), .N_CH(4), .RAM_WORDS(16), .RAM_ADDR_BITS(4))
        u_dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));
    collatz_range_mc #(.N_BITS(32), .CNT_BITS(4), .N_CH(4), .RAM_WORDS(16), .RAM_ADDR_BITS(4))
        u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));

    assign if0.go = go;  assign if0.start = start;      assign if0.rd_addr = rd_addr;
    assign if1.go = go;  assign if1.start = start;      assign if1.rd_addr = rd_addr;
    assign if2.go = go;  assign if2.start = start;      assign if2.rd_addr = rd_addr;
    assign if3.go = go;  assign if3.start = start[7:0]; assign if3.rd_addr = rd_addr;
    assign if4.go = go;  assign if4.start = start;      assign if4.rd_addr = rd_addr;

    logic [15:0] cnt_w  [NDUT];
    logic        flag_w [NDUT];
    logic        busy_w [NDUT];
    logic        done_w [NDUT];

    assign cnt_w[0] = if0.count; assign flag_w[0] = if0.flag;
    assign cnt_w[1] = if1.count; assign flag_w[1] = if1.flag;
    assign cnt_w[2] = if2.count; assign flag_w[2] = if2.flag;
    assign cnt_w[3] = if3.count; assign flag_w[3] = if3.flag;
    assign cnt_w[4] = {12'd0, if4.count}; assign flag_w[4] = if4.flag;
    assign busy_w[0] = if0.busy; assign done_w[0] = if0.done;
    assign busy_w[1] = if1.busy; assign done_w[1] = if1.done;
    assign busy_w[2] = if2.busy; assign done_w[2] = if2.done;
    assign busy_w[3] = if3.busy; assign done_w[3] = if3.done;
    assign busy_w[4] = if4.busy; assign done_w[4] = if4.done;

    int nb_of [NDUT] = '{32, 32, 32, 8, 32};
    int cb_of [NDUT] = '{16, 16, 16, 16, 4};

    typedef struct {
        int          dut;
        logic [31:0] start;
        int          addr;
        logic [15:0] cnt;
        logic        flag;
    } vec_t;

    typedef struct {
        int          dut;
        int          addr;
        logic [15:0] cnt;
        logic        flag;
        string       name;
    } exp_t;

    vec_t vecs [$];
    exp_t req_q [$];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   done_cyc [NDUT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Term count reference: {flag, count} for n reduced to nb bits, count limited to cb bits.
    function automatic logic [16:0] kref(input logic [31:0] n, input int nb, input int cb);
        logic [63:0] v;
        logic [63:0] lim;
        int          c;
        int          mx;
        mx  = (1 << cb) - 1;
        lim = (64'd1 << nb) - 64'd1;
        v   = {32'd0, n} & lim;
        if (v == 64'd0) return {1'b1, 16'(mx)};
        c = 1;
        while (v != 64'd1) begin
            if (c == mx) return {1'b1, 16'(mx)};
            if (v[0]) begin
                if (v * 3 + 64'd1 > lim) return {1'b1, 16'(c)};
                v = v * 3 + 64'd1;
            end else begin
                v = v >> 1;
            end
            c++;
        end
        return {1'b0, 16'(c)};
    endfunction

    task automatic add_table_reads(input logic [31:0] s);
        foreach (vecs[i]) begin
            if (vecs[i].start == s) begin
                req_q.push_back('{vecs[i].dut, vecs[i].addr, vecs[i].cnt, vecs[i].flag,
                                  $sformatf("tbl_s%0d_d%0d_a%0d", s, vecs[i].dut, vecs[i].addr)});
            end
        end
    endtask

    task automatic add_model_reads(input logic [31:0] s);
        logic [16:0] r;
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 16; a++) begin
                r = kref(s + 32'(a), nb_of[d], cb_of[d]);
                req_q.push_back('{d, a, r[15:0], r[16], $sformatf("ref_s%0d_d%0d_a%0d", s, d, a)});
            end
        end
    endtask

    // Address driven one cycle, data compared after the next edge.
    task automatic run_reads();
        exp_t e;
        int   n;
        n = req_q.size();
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, "_cnt"}, 32'(cnt_w[e.dut]), 32'(e.cnt));
                chk({e.name, "_flag"}, 32'(flag_w[e.dut]), 32'(e.flag));
            end
            if (i < n) begin
                rd_addr = 4'(req_q[i].addr);
                sb.push_back(req_q[i]);
            end
        end
        req_q.delete();
    endtask

    task automatic pulse_go(input logic [31:0] s);
        @(posedge clk);
        #1;
        go    = 1'b1;
        start = s;
        @(posedge clk);
        #1;
        go = 1'b0;
        chk("busy_after_go", 32'(busy_w[0]), 32'd1);
        chk("done_after_go", 32'(done_w[0]), 32'd0);
    endtask

    task automatic wait_done();
        logic busy_prev [NDUT];
        bit   all_done;
        int   n;
        for (int d = 0; d < NDUT; d++) busy_prev[d] = 1'b1;
        all_done = 1'b0;
        n        = 0;
        while (n < 6000 && !all_done) begin
            @(negedge clk);
            n++;
            all_done = 1'b1;
            for (int d = 0; d < NDUT; d++) begin
                if (busy_prev[d] && !busy_w[d]) begin
                    chk($sformatf("done_with_busy_fall_d%0d", d), 32'(done_w[d]), 32'd1);
                    done_cyc[d] = n;
                end
                busy_prev[d] = busy_w[d];
                if (!done_w[d]) all_done = 1'b0;
            end
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL wait_done timeout actual=%0d cycles required=done", n);
        end
    endtask

    int k1 [16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};

    initial begin
        for (int a = 0; a < 16; a++) vecs.push_back('{0, 32'd1, a, 16'(k1[a]), 1'b0});
        vecs.push_back('{0, 32'd0, 0, 16'hFFFF, 1'b1});
        vecs.push_back('{0, 32'd0, 1, 16'd1, 1'b0});
        vecs.push_back('{0, 32'd0, 2, 16'd2, 1'b0});
        vecs.push_back('{0, 32'd0, 3, 16'd8, 1'b0});
        vecs.push_back('{3, 32'd27, 0, 16'd12, 1'b1});
        vecs.push_back('{3, 32'd27, 1, 16'd19, 1'b0});
        vecs.push_back('{4, 32'd27, 0, 16'd15, 1'b1});
        vecs.push_back('{4, 32'd27, 1, 16'd15, 1'b1});
        vecs.push_back('{4, 32'd27, 2, 16'd15, 1'b1});
        vecs.push_back('{4, 32'd27, 5, 16'd6, 1'b0});
        vecs.push_back('{0, 32'd100, 0, 16'd26, 1'b0});

        reset_n = 1'b0;
        go      = 1'b0;
        start   = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_busy_d%0d", d), 32'(busy_w[d]), 32'd0);
            chk($sformatf("rst_done_d%0d", d), 32'(done_w[d]), 32'd0);
            chk($sformatf("rst_cnt_d%0d", d), 32'(cnt_w[d]), 32'd0);
            chk($sformatf("rst_flag_d%0d", d), 32'(flag_w[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        pulse_go(32'd1);
        wait_done();
        checks++;
        if (done_cyc[2] >= done_cyc[1]) begin
            errors++;
            $display("FAIL nch8_shorter actual=%0d required<%0d", done_cyc[2], done_cyc[1]);
        end
        add_table_reads(32'd1);
        add_model_reads(32'd1);
        run_reads();

        pulse_go(32'd0);
        wait_done();
        add_table_reads(32'd0);
        add_model_reads(32'd0);
        run_reads();

        pulse_go(32'd27);
        wait_done();
        add_table_reads(32'd27);
        add_model_reads(32'd27);
        run_reads();

        // Abort: restart from 100 while the run from 1 is still in flight.
        pulse_go(32'd1);
        repeat (9) @(posedge clk);
        pulse_go(32'd100);
        wait_done();
        add_table_reads(32'd100);
        add_model_reads(32'd100);
        run_reads();

        // Asynchronous reset in the middle of a run.
        pulse_go(32'd27);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("midrst_busy_d%0d", d), 32'(busy_w[d]), 32'd0);
            chk($sformatf("midrst_done_d%0d", d), 32'(done_w[d]), 32'd0);
            chk($sformatf("midrst_cnt_d%0d", d), 32'(cnt_w[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        pulse_go(32'hFFFF_FFF8);
        wait_done();
        add_model_reads(32'hFFFF_FFF8);
        run_reads();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
